ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_ctrl.sv | 90 +++++++++
 tb/tb_ifetch_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory read per PC,
// buffers the returned word for decode, and absorbs redirects (flush).
module ifetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  input  logic        flush,
  output logic        keep_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [31:0] instr_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] id_instr_reg;
  logic [31:0] id_pc4_reg;
  logic [31:0] count_reg;
  logic        capture;
  logic        handshake;

  assign capture   = (state_reg == REQ)  && mem_ack  && !flush;
  assign handshake = (state_reg == HOLD) && id_ready && !flush;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (flush)        state_next = mem_ack ? REQ : DROP;
        else if (mem_ack) state_next = HOLD;
      end
      HOLD: begin
        if (flush || id_ready) state_next = REQ;
      end
      DROP: begin
        if (mem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= 32'd0;
      id_instr_reg <= 32'd0;
      id_pc4_reg   <= 32'd0;
      count_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == REQ) addr_reg <= pc_in;
      if (capture) begin
        id_instr_reg <= mem_rdata;
        id_pc4_reg   <= pc4_in;
      end
      if (handshake) count_reg <= count_reg + 32'd1;
    end
  end

  // A flushed request still in flight must finish at its original address.
  assign mem_addr = (state_reg == DROP) ? addr_reg : pc_in;
  assign mem_req  = !rst && ((state_reg == REQ) || (state_reg == DROP));
  assign id_valid = !rst && (state_reg == HOLD);

  always_comb begin
    keep_pc = 1'b1;
    if (!rst) begin
      if (flush)                                keep_pc = 1'b0;
      else if ((state_reg == REQ) && mem_ack)   keep_pc = 1'b0;
    end
  end

  assign id_instr    = id_instr_reg;
  assign id_pc4      = id_pc4_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl with a PC-register model and a
// combinational memory whose data is the address xor a fixed key.
module tb_ifetch_ctrl;

  localparam logic [31:0] KEY = 32'h1357_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pc4;
  logic        flush;
  logic [31:0] target;
  logic        keep_pc, mem_req, mem_ack, id_valid, id_ready;
  logic [31:0] mem_addr, mem_rdata, id_instr, id_pc4, instr_count;
  logic        ack_tie, ack_force;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign pc4       = pc + 32'd4;
  assign mem_ack   = ack_tie ? mem_req : ack_force;
  assign mem_rdata = mem_addr ^ KEY;

  // External PC register: loads redirect target on flush, else pc+4.
  always @(posedge clk or posedge rst) begin
    if (rst)           pc <= 32'd0;
    else if (!keep_pc) pc <= flush ? target : pc4;
  end

  ifetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_in(pc), .pc4_in(pc4), .flush(flush),
    .keep_pc(keep_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc4(id_pc4),
    .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; target = 32'd0; id_ready = 1'b1;
    ack_tie = 1'b1; ack_force = 1'b0;
    #2;
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst keep_pc", {31'd0, keep_pc}, 32'd1);
    check("rst id_valid", {31'd0, id_valid}, 32'd0);
    check("rst id_instr", id_instr, 32'd0);
    check("rst id_pc4", id_pc4, 32'd0);
    check("rst count", instr_count, 32'd0);

    // Zero-wait streaming from PC 0
    @(negedge clk); rst = 1'b0; #1;
    check("idle mem_req", {31'd0, mem_req}, 32'd0);
    check("idle keep_pc", {31'd0, keep_pc}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stream%0d mem_req", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("stream%0d addr", i), mem_addr, 32'(4 * i));
      check($sformatf("stream%0d keep_pc", i), {31'd0, keep_pc}, 32'd0);
      tick();
      check($sformatf("stream%0d id_valid", i), {31'd0, id_valid}, 32'd1);
      check($sformatf("stream%0d id_instr", i), id_instr, 32'(4 * i) ^ KEY);
      check($sformatf("stream%0d id_pc4", i), id_pc4, 32'(4 * i + 4));
      check($sformatf("stream%0d hold mem_req", i), {31'd0, mem_req}, 32'd0);
      if (i == 2) ack_tie = 1'b0;
      tick();
    end
    check("stream count", instr_count, 32'd3);
    check("wait addr 0xc", mem_addr, 32'h0000_000c);
    check("wait keep_pc", {31'd0, keep_pc}, 32'd1);

    // Flush in REQ without ack: 0xC outstanding, redirect to 0x100
    flush = 1'b1; target = 32'h100; #1;
    check("flushreq keep_pc", {31'd0, keep_pc}, 32'd0);
    tick(); flush = 1'b0; #1;
    check("drop1 addr", mem_addr, 32'h0000_000c);
    check("drop1 keep_pc", {31'd0, keep_pc}, 32'd1);
    check("drop1 id_valid", {31'd0, id_valid}, 32'd0);
    tick();
    check("drop2 addr", mem_addr, 32'h0000_000c);
    ack_force = 1'b1; #1;
    check("drop ack keep_pc", {31'd0, keep_pc}, 32'd1);
    tick(); ack_force = 1'b0; #1;
    check("after drop addr", mem_addr, 32'h100);
    check("after drop instr", id_instr, 32'h8 ^ KEY);

    // Flush 0x100 -> 0x200, ack arrives in the first DROP cycle
    flush = 1'b1; target = 32'h200;
    tick(); flush = 1'b0; ack_force = 1'b1; #1;
    check("drop 0x100 addr", mem_addr, 32'h100);
    check("drop 0x100 req", {31'd0, mem_req}, 32'd1);
    tick(); ack_force = 1'b0; #1;
    check("redirect addr", mem_addr, 32'h200);
    check("redirect count", instr_count, 32'd3);
    check("redirect instr", id_instr, 32'h8 ^ KEY);

    // Flush in REQ with ack: data discarded, straight back to REQ at 0x40
    flush = 1'b1; target = 32'h40; ack_force = 1'b1; #1;
    check("flush+ack keep_pc", {31'd0, keep_pc}, 32'd0);
    tick(); flush = 1'b0; ack_force = 1'b0; #1;
    check("flush+ack id_valid", {31'd0, id_valid}, 32'd0);
    check("flush+ack instr", id_instr, 32'h8 ^ KEY);

    // Ack delayed 3 cycles at 0x40
    for (int i = 0; i < 3; i++) begin
      check($sformatf("slow%0d req", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("slow%0d addr", i), mem_addr, 32'h40);
      check($sformatf("slow%0d keep_pc", i), {31'd0, keep_pc}, 32'd1);
      tick();
    end
    ack_force = 1'b1; id_ready = 1'b0; #1;
    check("slow ack addr", mem_addr, 32'h40);
    check("slow ack keep_pc", {31'd0, keep_pc}, 32'd0);
    tick();
    check("slow id_instr", id_instr, 32'h40 ^ KEY);
    check("slow id_pc4", id_pc4, 32'h44);

    // Decode stalls 5 cycles; mem_ack held high must be ignored
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d id_valid", i), {31'd0, id_valid}, 32'd1);
      check($sformatf("stall%0d id_instr", i), id_instr, 32'h40 ^ KEY);
      check($sformatf("stall%0d mem_req", i), {31'd0, mem_req}, 32'd0);
      check($sformatf("stall%0d count", i), instr_count, 32'd3);
      tick();
    end
    ack_force = 1'b0; id_ready = 1'b1; #1;
    check("release id_valid", {31'd0, id_valid}, 32'd1);
    tick();
    check("release count", instr_count, 32'd4);
    check("release addr", mem_addr, 32'h44);

    // Flush in HOLD with id_ready=1: buffer dropped, no count
    ack_force = 1'b1;
    tick(); ack_force = 1'b0; flush = 1'b1; target = 32'h80; #1;
    check("flushhold id_valid", {31'd0, id_valid}, 32'd1);
    check("flushhold keep_pc", {31'd0, keep_pc}, 32'd0);
    tick(); flush = 1'b0; #1;
    check("flushhold next valid", {31'd0, id_valid}, 32'd0);
    check("flushhold count", instr_count, 32'd4);
    check("flushhold addr", mem_addr, 32'h80);
    check("flushhold req", {31'd0, mem_req}, 32'd1);

    // Reset during an outstanding request
    rst = 1'b1; #1;
    check("midrst mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst keep_pc", {31'd0, keep_pc}, 32'd1);
    check("midrst count", instr_count, 32'd0);
    check("midrst id_instr", id_instr, 32'd0);
    tick();
    @(negedge clk); rst = 1'b0; ack_tie = 1'b1; #1;
    check("post-rst idle req", {31'd0, mem_req}, 32'd0);
    tick();
    check("post-rst req", {31'd0, mem_req}, 32'd1);
    check("post-rst addr", mem_addr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
